// File: rtl/bus_transfer_sequencer_if.sv
// Request handshake and bus-enable bundle between the control unit and the move sequencer.
// bus_out is not bundled here; it is a tri-state net and stays a plain port on the sequencer.
interface bus_transfer_sequencer_if #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned SEL_W    = 3
);
    logic                req_valid;
    logic                req_ready;
    logic [SEL_W-1:0]    req_src;
    logic [SEL_W-1:0]    req_dst;
    logic                req_imm;
    logic [7:0]          req_data;
    logic [NUM_REGS-1:0] read_en;
    logic [NUM_REGS-1:0] write_en;
    logic                imm_drive;
    logic                busy;
    logic                done;
    logic                err;
    logic [7:0]          xfer_count;

    modport master (
        output req_valid, req_src, req_dst, req_imm, req_data,
        input  req_ready, read_en, write_en, imm_drive, busy, done, err, xfer_count
    );

    modport slave (
        input  req_valid, req_src, req_dst, req_imm, req_data,
        output req_ready, read_en, write_en, imm_drive, busy, done, err, xfer_count
    );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Sequences register-to-register and immediate-to-register moves over the shared 8-bit bus:
// SETTLE drives the source, COMMIT adds the destination write, DONE reports completion.
module bus_transfer_sequencer #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      res,
    bus_transfer_sequencer_if.slave   bus,
    output wire  [7:0]                bus_out
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [SEL_W-1:0]    src_q, src_d;
    logic [SEL_W-1:0]    dst_q, dst_d;
    logic                imm_q, imm_d;
    logic [7:0]          data_q, data_d;
    logic                bad_q, bad_d;
    logic [7:0]          count_q, count_d;

    logic [NUM_REGS-1:0] read_en_q, read_en_d;
    logic [NUM_REGS-1:0] write_en_q, write_en_d;
    logic                imm_drive_q, imm_drive_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                req_bad;
    logic                src_on;

    assign req_bad = (32'(bus.req_dst) >= NUM_REGS) ||
                     (!bus.req_imm && ((32'(bus.req_src) >= NUM_REGS) ||
                                       (bus.req_src == bus.req_dst)));

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
        data_d  = data_q;
        bad_d   = bad_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    src_d   = bus.req_src;
                    dst_d   = bus.req_dst;
                    imm_d   = bus.req_imm;
                    data_d  = bus.req_data;
                    bad_d   = req_bad;
                    state_d = req_bad ? ST_DONE : ST_SETTLE;
                end
            end
            ST_SETTLE: state_d = ST_COMMIT;
            ST_COMMIT: begin
                state_d = ST_DONE;
                count_d = count_q + 8'd1;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Enables are decoded from the next state so they come straight out of flops.
    always_comb begin
        src_on      = (state_d == ST_SETTLE) || (state_d == ST_COMMIT);
        read_en_d   = '0;
        write_en_d  = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            read_en_d[i]  = src_on && !imm_d && (32'(src_d) == i);
            write_en_d[i] = (state_d == ST_COMMIT) && (32'(dst_d) == i);
        end
        imm_drive_d = src_on && imm_d;
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_DONE) && bad_d;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            imm_q       <= 1'b0;
            data_q      <= 8'h00;
            bad_q       <= 1'b0;
            count_q     <= 8'h00;
            read_en_q   <= '0;
            write_en_q  <= '0;
            imm_drive_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            imm_q       <= imm_d;
            data_q      <= data_d;
            bad_q       <= bad_d;
            count_q     <= count_d;
            read_en_q   <= read_en_d;
            write_en_q  <= write_en_d;
            imm_drive_q <= imm_drive_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.read_en    = read_en_q;
    assign bus.write_en   = write_en_q;
    assign bus.imm_drive  = imm_drive_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.xfer_count = count_q;

    assign bus_out = imm_drive_q ? data_q : 8'bzzzzzzzz;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench for bus_transfer_sequencer: a vector table, random moves against a
// register-file reference model, and hand sequences for reset corner cases.
module tb_bus_transfer_sequencer;
    localparam int unsigned NR = 4;
    localparam int unsigned SW = 3;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    wire  [7:0] data_bus;

    bus_transfer_sequencer_if #(.NUM_REGS(NR), .SEL_W(SW)) bus_if ();

    bus_transfer_sequencer #(.NUM_REGS(NR), .SEL_W(SW)) dut (
        .clk     (clk),
        .res     (res),
        .bus     (bus_if),
        .bus_out (data_bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] src;
        logic [2:0] dst;
        logic       imm;
        logic [7:0] data;
    } req_t;

    typedef struct {
        req_t       r;
        logic       e_err;
        logic [3:0] e_rd;
        logic [3:0] e_wr;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    int         succ  = 0;
    logic [7:0] cnt   = 8'h00;
    logic [7:0] regs  [4];
    logic [7:0] mregs [4];
    vec_t       vt    [9];

    function automatic logic [20:0] pk(input logic rdy, input logic bsy, input logic dn,
                                       input logic er, input logic im, input logic [3:0] rd,
                                       input logic [3:0] wr, input logic [7:0] c);
        return {rdy, bsy, dn, er, im, rd, wr, c};
    endfunction

    function automatic logic [20:0] obs();
        return {bus_if.req_ready, bus_if.busy, bus_if.done, bus_if.err, bus_if.imm_drive,
                bus_if.read_en, bus_if.write_en, bus_if.xfer_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: validity and one-hot enables straight from the move rules.
    function automatic void ref_expect(input req_t r, output logic e, output logic [3:0] rd,
                                       output logic [3:0] wr);
        int s = int'(r.src);
        int d = int'(r.dst);
        e  = (d >= int'(NR)) || (!r.imm && ((s >= int'(NR)) || (s == d)));
        rd = 4'b0000;
        wr = 4'b0000;
        if (!e) begin
            if (!r.imm) rd[s] = 1'b1;
            wr[d] = 1'b1;
        end
    endfunction

    function automatic vec_t mk(input logic [2:0] s, input logic [2:0] d, input logic im,
                                input logic [7:0] dat, input logic e, input logic [3:0] rd,
                                input logic [3:0] wr);
        vec_t v;
        v.r.src  = s;
        v.r.dst  = d;
        v.r.imm  = im;
        v.r.data = dat;
        v.e_err  = e;
        v.e_rd   = rd;
        v.e_wr   = wr;
        return v;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.src  = 3'($urandom_range(0, 7));
        r.dst  = 3'($urandom_range(0, 5));
        r.imm  = 1'($urandom_range(0, 1));
        r.data = 8'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic drive(input req_t r, input logic v);
        bus_if.req_src   = r.src;
        bus_if.req_dst   = r.dst;
        bus_if.req_imm   = r.imm;
        bus_if.req_data  = r.data;
        bus_if.req_valid = v;
    endtask

    // Entered at a falling edge with the DUT idle; leaves at the falling edge of its next idle.
    task automatic do_move(input req_t r, input logic e_err, input logic [3:0] e_rd,
                           input logic [3:0] e_wr, input logic hold, input req_t nxt);
        logic [7:0] sv;
        drive(r, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (hold) drive(nxt, 1'b1);
        else      drive(nxt, 1'b0);
        if (e_err) begin
            check("reject done", 32'(obs()),
                  32'(pk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, cnt)));
            @(negedge clk);
            check("reject idle", 32'(obs()),
                  32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, cnt)));
        end else begin
            check("settle", 32'(obs()),
                  32'(pk(1'b0, 1'b1, 1'b0, 1'b0, r.imm, e_rd, 4'b0000, cnt)));
            if (r.imm) check("bus settle", 32'(data_bus), 32'(r.data));
            @(negedge clk);
            check("commit", 32'(obs()),
                  32'(pk(1'b0, 1'b1, 1'b0, 1'b0, r.imm, e_rd, e_wr, cnt)));
            if (r.imm) check("bus commit", 32'(data_bus), 32'(r.data));
            sv = 8'h00;
            if (bus_if.imm_drive) sv = data_bus;
            for (int i = 0; i < 4; i++) if (bus_if.read_en[i]) sv = regs[i];
            for (int i = 0; i < 4; i++) if (bus_if.write_en[i]) regs[i] = sv;
            @(negedge clk);
            cnt = cnt + 8'd1;
            check("done", 32'(obs()),
                  32'(pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, cnt)));
            mregs[r.dst[1:0]] = r.imm ? r.data : mregs[r.src[1:0]];
            check("reg value", 32'(regs[r.dst[1:0]]), 32'(mregs[r.dst[1:0]]));
            @(negedge clk);
            check("idle", 32'(obs()),
                  32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, cnt)));
        end
    endtask

    initial begin
        req_t       cur;
        req_t       nx;
        logic       e;
        logic [3:0] rd;
        logic [3:0] wr;
        int         loops;

        for (int i = 0; i < 4; i++) begin
            regs[i]  = 8'h10 + 8'(i);
            mregs[i] = 8'h10 + 8'(i);
        end
        regs[1]  = 8'hA5;
        mregs[1] = 8'hA5;
        cur = '0;
        drive(cur, 1'b0);

        vt[0] = mk(3'd1, 3'd3, 1'b0, 8'h00, 1'b0, 4'b0010, 4'b1000);
        vt[1] = mk(3'd0, 3'd0, 1'b1, 8'h3C, 1'b0, 4'b0000, 4'b0001);
        vt[2] = mk(3'd0, 3'd5, 1'b0, 8'h00, 1'b1, 4'b0000, 4'b0000);
        vt[3] = mk(3'd2, 3'd2, 1'b0, 8'h00, 1'b1, 4'b0000, 4'b0000);
        vt[4] = mk(3'd3, 3'd0, 1'b0, 8'h00, 1'b0, 4'b1000, 4'b0001);
        vt[5] = mk(3'd2, 3'd2, 1'b1, 8'h5A, 1'b0, 4'b0000, 4'b0100);
        vt[6] = mk(3'd4, 3'd1, 1'b0, 8'h00, 1'b1, 4'b0000, 4'b0000);
        vt[7] = mk(3'd0, 3'd4, 1'b1, 8'h77, 1'b1, 4'b0000, 4'b0000);
        vt[8] = mk(3'd0, 3'd2, 1'b0, 8'h00, 1'b0, 4'b0001, 4'b0100);

        // Reset asserted between clock edges.
        #2 res = 1'b1;
        #1 check("reset outputs", 32'(obs() & 21'h0FFFFF), 32'h0);
        repeat (2) @(negedge clk);
        res = 1'b0;
        check("ready after reset", 32'(obs()),
              32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00)));

        // Table vectors, with the next request held valid while the current one is busy.
        for (int i = 0; i < 9; i++) begin
            do_move(vt[i].r, vt[i].e_err, vt[i].e_rd, vt[i].e_wr, i < 8, vt[(i + 1) % 9].r);
        end
        check("reg3 from reg1", 32'(regs[3]), 32'h0000_00A5);

        // Random moves until the commit counter has wrapped.
        loops = 0;
        cur = rnd_req();
        while (succ < 270 && loops < 1500) begin
            nx = rnd_req();
            ref_expect(cur, e, rd, wr);
            do_move(cur, e, rd, wr, 1'($urandom_range(0, 1)), nx);
            if (!e) succ++;
            cur = nx;
            loops++;
        end

        // Reset pulse during COMMIT.
        cur.src = 3'd0; cur.dst = 3'd1; cur.imm = 1'b0; cur.data = 8'h00;
        drive(cur, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        check("commit before reset", 32'(obs()),
              32'(pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0010, cnt)));
        #2 res = 1'b1;
        #1 check("async enable drop", 32'(obs() & 21'h0FFFFF), 32'h0);
        @(negedge clk);
        res = 1'b0;
        cnt = 8'h00;
        check("idle after reset", 32'(obs()),
              32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00)));
        ref_expect(cur, e, rd, wr);
        do_move(cur, e, rd, wr, 1'b0, cur);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_transfer_sequencer.md
Name: bus_transfer_sequencer

Overview:
Sequences register-to-register and immediate-to-register moves over the shared 8-bit tri-state data bus of the model computer. It accepts one move request at a time through a valid/ready handshake. It then drives the one-hot read_enable and write_enable lines of up to NUM_REGS bus registers, so that exactly one source drives the bus and the destination captures it. It sits between the instruction decode/control unit and the register file / bus.

Parameters:
NUM_REGS, 4, number of bus registers controlled (1..8).
SEL_W, 3, width of the source/destination selects; 2^SEL_W >= NUM_REGS.

Ports:
clk  input  1  system clock, all state on rising edge
res  input  1  reset; asynchronous, active-high
req_valid  input  1  move request present
req_ready  output  1  sequencer can accept a request; high only in IDLE
req_src  input  SEL_W  source register index; ignored when req_imm=1
req_dst  input  SEL_W  destination register index
req_imm  input  1  1 = source is req_data (immediate), 0 = source is register req_src
req_data  input  8  immediate value
read_en  output  NUM_REGS  one-hot read enables to bus registers
write_en  output  NUM_REGS  one-hot write enables to bus registers
bus_out  output  8  drives latched immediate onto the bus when imm_drive=1, else 8'bzzzzzzzz
imm_drive  output  1  sequencer is driving the bus
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at end of every accepted request
err  output  1  one-cycle pulse coincident with done for a rejected request
xfer_count  output  8  number of successful commits, wraps 255->0

Behaviour:
- Reset (res=1, asynchronous): state=IDLE; read_en=0, write_en=0, imm_drive=0, bus_out=Z, busy=0, done=0, err=0, xfer_count=0, latched request fields=0. req_ready=1 once res deasserts.
- Reset mid-transfer: all enables drop immediately; no partial write is counted; return to IDLE.
- All enables, done and err are registered (Moore from state plus latched fields). No combinational path from req_* to enables.
- Accept: req_valid && req_ready at rising edge T latches src, dst, imm and data, and leaves IDLE. req_valid while busy is ignored; the requester holds it.
- Validation happens at accept. The request is invalid if dst >= NUM_REGS, or (!imm && src >= NUM_REGS), or (!imm && src == dst).
- Valid request timeline (cycles after edge T):
  - T+1 SETTLE: source enable on (read_en[src]=1, or imm_drive=1 with bus_out=data); write_en=0.
  - T+2 COMMIT: source enable held; write_en[dst]=1. The destination captures at the end of this cycle. xfer_count increments at the edge ending COMMIT.
  - T+3 DONE: all enables 0, done=1, err=0.
  - T+4: IDLE, req_ready=1. A new request can be accepted at the edge ending T+4. Throughput is one move per 4 cycles.
- Invalid request: T+1 goes directly to DONE with done=1 and err=1. No enable is asserted in any cycle and xfer_count is unchanged. IDLE at T+2.
- Invariants:
  - read_en is zero or one-hot.
  - write_en is zero or one-hot.
  - read_en and imm_drive are never both active.
  - write_en is never active without a bus source active in the same cycle.
  - No source is ever active in IDLE or DONE.
- Illegal state encodings recover to IDLE on the next clock with all outputs low.
- req_imm=1 with src == dst is valid; src is ignored.

Test Plan:
- Reset: assert res mid-cycle -> all enables 0, bus_out=Z, xfer_count=0, req_ready=1 after release.
- Register move src=1 dst=3, with reg1 preloaded 8'hA5 -> read_en=4'b0010 for 2 cycles, write_en=4'b1000 in the 2nd only, done at T+3, reg3=8'hA5, xfer_count=1.
- Immediate req_imm=1 data=8'h3C dst=0 -> imm_drive=1 for 2 cycles, bus_out=8'h3C, write_en=4'b0001 in COMMIT, reg0=8'h3C; bus_out=Z in IDLE.
- Errors: dst=5, and separately src=dst=2 -> done=err=1 at T+1, read_en/write_en stay 0, xfer_count unchanged.
- Back-to-back with req_valid held high during busy -> second request accepted only when req_ready=1, 4-cycle spacing, never two bus sources; 256 moves make xfer_count wrap to 0.
- res pulse during COMMIT -> write_en drops asynchronously, xfer_count not incremented, IDLE on release.
